// File: rtl/dmem_dump_pkg.sv
// Shared definitions for the data-memory dump engine: FSM state encoding
// and the default debug-port geometry of the data BRAM.
package dmem_dump_pkg;

    localparam int DMEM_ADDR_WIDTH  = 10;
    localparam int DMEM_DATA_WIDTH  = 32;
    localparam int DUMP_COUNT_WIDTH = 9;
    localparam int DUMP_WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_FETCH = 2'd1,
        DUMP_SEND  = 2'd2,
        DUMP_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/dmem_dump.sv
// Data-memory read-back engine. Walks a word-aligned region of the data
// BRAM through its combinational debug read port and streams each word,
// tagged with its byte address, over a valid/ready interface. While a dump
// is active, busy is high so the core can be stalled and memory frozen.
module dmem_dump
    import dmem_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [DUMP_COUNT_WIDTH-1:0] word_count,
    input  logic                        abort,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [ADDR_WIDTH-1:0]       m_addr,
    output logic                        m_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(DUMP_WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DUMP_WORD_BYTES - 1);

    dump_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]       rd_addr_q, rd_addr_d;
    logic [DUMP_COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                        m_valid_q, m_valid_d;
    logic                        m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0]       m_data_q, m_data_d;
    logic [ADDR_WIDTH-1:0]       m_addr_q, m_addr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        handshake;

    assign handshake = m_valid_q & m_ready;

    // Next-state logic: FSM, address/word counters and the output beat register.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        m_addr_d    = m_addr_q;

        case (state_q)
            DUMP_IDLE: begin
                if (start) begin
                    // Low address bits are dropped: the dump is always word aligned.
                    rd_addr_d   = base_addr & ALIGN_MASK;
                    remaining_d = word_count;
                    state_d     = (word_count == '0) ? DUMP_DONE : DUMP_FETCH;
                end
            end
            DUMP_FETCH: begin
                if (abort) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = DUMP_IDLE;
                end else begin
                    m_data_d  = mem_data;
                    m_addr_d  = rd_addr_q;
                    rd_addr_d = rd_addr_q + WORD_STEP;
                    m_last_d  = (remaining_q == DUMP_COUNT_WIDTH'(1));
                    m_valid_d = 1'b1;
                    state_d   = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                // Abort wins over a same-cycle handshake; that beat is dropped.
                if (abort) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = DUMP_IDLE;
                end else if (handshake) begin
                    remaining_d = remaining_q - DUMP_COUNT_WIDTH'(1);
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = DUMP_DONE;
                    end else begin
                        // Refill the beat register in the handshake cycle so a
                        // continuously ready sink gets one word per clock.
                        m_data_d  = mem_data;
                        m_addr_d  = rd_addr_q;
                        rd_addr_d = rd_addr_q + WORD_STEP;
                        m_last_d  = (remaining_q == DUMP_COUNT_WIDTH'(2));
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        done_d = (state_d == DUMP_DONE);
        busy_d = (state_d != DUMP_IDLE);
    end

    // State and output registers; asynchronous reset clears every output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DUMP_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            m_addr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            m_addr_q    <= m_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr = rd_addr_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;
    assign m_addr   = m_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump with a small combinational data-memory model.
module tb_dmem_dump;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [8:0]    word_count = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_last;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:255];

    assign mem_data = mem[mem_addr[AW-1:2]];

    dmem_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .mem_addr(mem_addr),
        .mem_data(mem_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole beat: {valid, last, addr, data}
    task automatic chk_beat(input string tag, input logic v, input logic l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk(tag, {20'd0, m_valid, m_last, m_addr, m_data}, {20'd0, v, l, a, d});
    endtask

    // Status: {busy, done}
    task automatic chk_stat(input string tag, input logic b, input logic dn);
        chk(tag, {62'd0, busy, done}, {62'd0, b, dn});
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [8:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;
        mem[254] = 32'hFEFE_0001;
        mem[255] = 32'hFFFF_0002;

        // Reset state
        tick();
        tick();
        chk_beat("rst_beat", 1'b0, 1'b0, 10'h000, 32'h0);
        chk_stat("rst_stat", 1'b0, 1'b0);
        chk("rst_memaddr", 64'(mem_addr), 64'h0);
        rst = 1'b1;
        tick();

        // Basic dump, 4 words back to back
        m_ready = 1'b1;
        go(10'h000, 9'd4);
        chk_beat("basic_fetch", 1'b0, 1'b0, 10'h000, 32'h0);
        chk_stat("basic_fetch_stat", 1'b1, 1'b0);
        tick();
        chk_beat("basic_b0", 1'b1, 1'b0, 10'h000, 32'h1111_1111);
        tick();
        chk_beat("basic_b1", 1'b1, 1'b0, 10'h004, 32'h2222_2222);
        tick();
        chk_beat("basic_b2", 1'b1, 1'b0, 10'h008, 32'h3333_3333);
        chk_stat("basic_b2_stat", 1'b1, 1'b0);
        tick();
        chk_beat("basic_b3", 1'b1, 1'b1, 10'h00C, 32'h4444_4444);
        tick();
        chk("basic_done_valid", {62'd0, m_valid, m_last}, 64'd0);
        chk_stat("basic_done", 1'b1, 1'b1);
        tick();
        chk_stat("basic_idle", 1'b0, 1'b0);

        // Backpressure, 3 words, ready pattern 1,0,0,1,0,1
        m_ready = 1'b0;
        go(10'h010, 9'd3);
        tick();
        chk_beat("bp_b0", 1'b1, 1'b0, 10'h010, 32'hA000_0004);
        m_ready = 1'b1;
        tick();
        chk_beat("bp_b1", 1'b1, 1'b0, 10'h014, 32'hA000_0005);
        m_ready = 1'b0;
        tick();
        chk_beat("bp_b1_hold1", 1'b1, 1'b0, 10'h014, 32'hA000_0005);
        tick();
        chk_beat("bp_b1_hold2", 1'b1, 1'b0, 10'h014, 32'hA000_0005);
        chk_stat("bp_stall_stat", 1'b1, 1'b0);
        m_ready = 1'b1;
        tick();
        chk_beat("bp_b2", 1'b1, 1'b1, 10'h018, 32'hA000_0006);
        m_ready = 1'b0;
        tick();
        chk_beat("bp_b2_hold", 1'b1, 1'b1, 10'h018, 32'hA000_0006);
        m_ready = 1'b1;
        tick();
        chk("bp_end_valid", 64'(m_valid), 64'd0);
        chk_stat("bp_done", 1'b1, 1'b1);
        tick();

        // Unaligned base with address wrap
        go(10'h3FA, 9'd3);
        chk("wrap_memaddr", 64'(mem_addr), 64'h3F8);
        tick();
        chk_beat("wrap_b0", 1'b1, 1'b0, 10'h3F8, 32'hFEFE_0001);
        tick();
        chk_beat("wrap_b1", 1'b1, 1'b0, 10'h3FC, 32'hFFFF_0002);
        tick();
        chk_beat("wrap_b2", 1'b1, 1'b1, 10'h000, 32'h1111_1111);
        tick();
        chk_stat("wrap_done", 1'b1, 1'b1);
        tick();

        // Zero count
        go(10'h040, 9'd0);
        chk("zero_valid", 64'(m_valid), 64'd0);
        chk_stat("zero_done", 1'b1, 1'b1);
        tick();
        chk("zero_valid2", 64'(m_valid), 64'd0);
        chk_stat("zero_idle", 1'b0, 1'b0);

        // Start while busy is ignored
        go(10'h020, 9'd2);
        tick();
        chk_beat("sb_b0", 1'b1, 1'b0, 10'h020, 32'hA000_0008);
        base_addr  = 10'h100;
        word_count = 9'd5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk_beat("sb_b1", 1'b1, 1'b1, 10'h024, 32'hA000_0009);
        tick();
        chk("sb_end_valid", 64'(m_valid), 64'd0);
        chk_stat("sb_done", 1'b1, 1'b1);
        tick();
        chk_stat("sb_idle", 1'b0, 1'b0);
        chk("sb_memaddr", 64'(mem_addr), 64'h028);
        tick();
        chk("sb_no_restart", {62'd0, m_valid, busy}, 64'd0);

        // Abort during the second beat
        go(10'h000, 9'd4);
        tick();
        tick();
        chk_beat("ab_b1", 1'b1, 1'b0, 10'h004, 32'h2222_2222);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_cleared", {62'd0, m_valid, m_last}, 64'd0);
        chk_stat("ab_stat", 1'b0, 1'b0);
        tick();
        chk_stat("ab_no_done", 1'b0, 1'b0);
        go(10'h00C, 9'd1);
        tick();
        chk_beat("ab_restart", 1'b1, 1'b1, 10'h00C, 32'h4444_4444);
        tick();
        chk_stat("ab_restart_done", 1'b1, 1'b1);
        tick();

        // Asynchronous reset mid-dump
        go(10'h000, 9'd4);
        tick();
        tick();
        chk_beat("ar_b1", 1'b1, 1'b0, 10'h004, 32'h2222_2222);
        #2;
        rst = 1'b0;
        #1;
        chk_beat("ar_beat", 1'b0, 1'b0, 10'h000, 32'h0);
        chk_stat("ar_stat", 1'b0, 1'b0);
        chk("ar_memaddr", 64'(mem_addr), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        go(10'h008, 9'd1);
        tick();
        chk_beat("ar_after", 1'b1, 1'b1, 10'h008, 32'h3333_3333);
        tick();
        chk_stat("ar_after_done", 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
